mtr_ramp_ctrl: RTL and testbench
================================

# mtr_ramp_ctrl

Slew-rate controller that sequences the speed commands fed into the motor driver (`lft_spd`/`rght_spd`). It accepts left and right target speeds from the navigation logic and ramps the driven speeds toward them in fixed steps at a fixed tick rate, so the PWM datapath never sees a step change. It also handles run/stop sequencing and emergency stop, and sits directly upstream of the motor driver's speed inputs.

## Interface
- `STEP`, default 16: magnitude added to or subtracted from each speed per tick in RUN and STOP (unsigned, 1..511).
- `BRAKE_STEP`, default 64: per-tick magnitude in ESTOP. Used only when `MTR_RAMP_BRAKE_EN` is defined.
- `TICK_DIV`, default 4096: clock cycles per ramp tick (≥2).
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `go` in 1: level request to run. 1 = follow targets; 0 = ramp to zero.
- `estop` in 1: emergency stop, level. Highest priority.
- `lft_tgt` in 12: signed left target speed.
- `rght_tgt` in 12: signed right target speed.
- `lft_spd` out 12: signed registered left speed command to the motor driver.
- `rght_spd` out 12: signed registered right speed command to the motor driver.
- `at_speed` out 1: state==RUN and both speeds equal their current targets.
- `ramping` out 1: state∈{RUN,STOP,ESTOP} and at least one speed is not equal to its destination.
- `fault` out 1: state==ESTOP.

## Operation
- States:
  - IDLE: speeds held 0, waiting for `go`.
  - RUN: ramp each speed toward its target.
  - STOP: ramp each speed toward 0.
  - ESTOP: drive to 0 and hold until cleared.
- Transitions, evaluated every cycle, in priority order:
  - `estop`=1 → ESTOP from any state.
  - IDLE, `go`=1 → RUN.
  - RUN, `go`=0 → STOP.
  - STOP, `go`=1 → RUN. Ramp resumes from the current speeds.
  - STOP, both speeds 0 → IDLE.
  - ESTOP, `estop`=0 and `go`=0 and both speeds 0 → IDLE. ESTOP is never left directly for RUN.
- Tick counter:
  - Counts 0..TICK_DIV-1.
  - Cleared on every state change.
  - Held at 0 in IDLE.
  - A step occurs on the cycle the counter equals TICK_DIV-1, and the counter wraps to 0.
- Step rule, per channel, with destination D (target in RUN, 0 in STOP/ESTOP) and step size S:
  - Compute diff = D − spd in 13-bit signed arithmetic. No overflow is possible over the full −2048..2047 range.
  - If |diff| ≤ S, spd ← D.
  - Otherwise spd ← spd + S·sign(diff), which always stays within 12-bit range.
- Targets are sampled live at each step. A target change mid-ramp redirects the ramp from the current value. Channels are independent; one may settle while the other still ramps.
- A target change while RUN and settled simply restarts ramping. The counter does not restart, so the first new step lands at the next counter wrap.

## Timing
- Reset values: `lft_spd`=0, `rght_spd`=0, state=IDLE, counter=0, `at_speed`=0, `ramping`=0, `fault`=0.
- Reset mid-ramp forces these values immediately (asynchronous).
- State changes one cycle after the input condition is sampled.
- First step after entering RUN/STOP/ESTOP (ramped mode): TICK_DIV cycles after the state-change edge.
- `lft_spd`/`rght_spd` change only on step edges, except for the ESTOP immediate-clear described under Configuration.
- `at_speed`, `ramping`, `fault` are combinational decodes of state, registered speeds and current targets. There is no extra latency.
- `estop` and `go` asserted in the same cycle: `estop` wins.
- `go` toggling within one tick period: the counter clears on each state change, so no step occurs until a full TICK_DIV elapses in a single state.

## Configuration
- `MTR_RAMP_BRAKE_EN` defined:
  - ESTOP ramps both speeds to 0 at BRAKE_STEP per tick.
  - `ramping` stays 1 until both speeds reach 0.
- `MTR_RAMP_BRAKE_EN` undefined:
  - The edge that enters ESTOP also clears both speeds to 0.
  - No counter activity in ESTOP.
  - BRAKE_STEP is unused.

## Test plan
- Reset, then `go`=1, `lft_tgt`=100, `rght_tgt`=−50, STEP=16, TICK_DIV=4.
  - Left sequence: 16, 32, 48, 64, 80, 96, 100.
  - Right sequence: −16, −32, −48, −50, then held.
  - `at_speed` rises at step 7, 28 cycles after RUN entry.
- Settled at 100/−50, drop `go`.
  - STOP ramps left 84, 68, … 4, 0 and right −34, −18, −2, 0.
  - IDLE is entered one cycle after both reach 0.
- Mid-ramp at `lft_spd`=48, change `lft_tgt` to −20.
  - Next steps give 32, 16, 0, −16, −20.
- At 2047/−2048 targets, reached from 0.
  - No wrap or overflow occurs.
  - Final values are exactly 2047 and −2048.
- `estop` at 100/−50.
  - Without the macro: 0/0 on the next edge, `fault`=1.
  - With the macro: 36, 0 and 0 (BRAKE_STEP=64).
  - Release `estop` while `go`=1: the block stays in ESTOP. Drop `go`: IDLE.
- Assert `rst_n`=0 mid-ramp.
  - Outputs go to 0 asynchronously.
  - After release, the block stays in IDLE until `go`.

Source files
------------

// File: rtl/mtr_ramp_ctrl_if.sv
// mtr_ramp_ctrl_if: speed command bundle between navigation and the ramp controller.
// master = navigation side, slave = ramp controller.
interface mtr_ramp_ctrl_if;
    logic               go;
    logic               estop;
    logic signed [11:0] lft_tgt;
    logic signed [11:0] rght_tgt;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               at_speed;
    logic               ramping;
    logic               fault;

    modport master (
        output go, estop, lft_tgt, rght_tgt,
        input  lft_spd, rght_spd, at_speed, ramping, fault
    );

    modport slave (
        input  go, estop, lft_tgt, rght_tgt,
        output lft_spd, rght_spd, at_speed, ramping, fault
    );
endinterface

// File: rtl/mtr_ramp_ctrl.sv
// mtr_ramp_ctrl: slew-limited left/right speed sequencer with run/stop/estop.
// MTR_RAMP_BRAKE_EN: ramp to zero at BRAKE_STEP in ESTOP instead of clearing.
module mtr_ramp_ctrl #(
    parameter int unsigned STEP       = 16,
    parameter int unsigned BRAKE_STEP = 64,
    parameter int unsigned TICK_DIV   = 4096
) (
    input logic             clk,
    input logic             rst_n,
    mtr_ramp_ctrl_if.slave  bus
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [12:0] S_RUN = 13'(STEP);
    localparam logic [12:0] S_BRK = 13'(BRAKE_STEP);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP,
        ESTOP
    } state_t;

    state_t             state;
    state_t             nxt;
    logic [CW-1:0]      cnt;
    logic signed [11:0] lft_q;
    logic signed [11:0] rght_q;
    logic signed [11:0] lft_d;
    logic signed [11:0] rght_d;
    logic [12:0]        sz;
    logic               zero;
    logic               chg;
    logic               cnt_en;
    logic               tick;

    // Saturating move of cur toward d by at most s, in 13-bit arithmetic.
    function automatic logic signed [11:0] step_to(
        input logic signed [11:0] d,
        input logic signed [11:0] cur,
        input logic [12:0]        s
    );
        logic signed [12:0] diff;
        logic [12:0]        mag;
        logic [12:0]        c13;
        logic [12:0]        res;
        diff = {d[11], d} - {cur[11], cur};
        mag  = diff[12] ? 13'(-diff) : 13'(diff);
        c13  = {cur[11], cur};
        res  = diff[12] ? (c13 - s) : (c13 + s);
        if (mag <= s)
            step_to = d;
        else
            step_to = $signed(res[11:0]);
    endfunction

    always_comb begin
        zero = (lft_q == 12'sd0) && (rght_q == 12'sd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (bus.estop) begin
            nxt = ESTOP;
        end else begin
            unique case (state)
                IDLE:  if (bus.go) nxt = RUN;
                RUN:   if (!bus.go) nxt = STOP;
                STOP: begin
                    if (bus.go)
                        nxt = RUN;
                    else if (zero)
                        nxt = IDLE;
                end
                ESTOP: if (!bus.go && zero) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        lft_d  = 12'sd0;
        rght_d = 12'sd0;
        sz     = S_RUN;
        cnt_en = 1'b0;
        unique case (state)
            RUN: begin
                lft_d  = bus.lft_tgt;
                rght_d = bus.rght_tgt;
                cnt_en = 1'b1;
            end
            STOP: cnt_en = 1'b1;
            ESTOP: begin
                sz = S_BRK;
`ifdef MTR_RAMP_BRAKE_EN
                cnt_en = 1'b1;
`else
                cnt_en = 1'b0;
`endif
            end
            default: cnt_en = 1'b0;
        endcase
        chg  = (nxt != state);
        tick = cnt_en && (cnt == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (chg || !cnt_en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q  <= 12'sd0;
            rght_q <= 12'sd0;
        end
`ifndef MTR_RAMP_BRAKE_EN
        // Hard stop: the edge entering ESTOP zeroes both channels.
        else if (nxt == ESTOP) begin
            lft_q  <= 12'sd0;
            rght_q <= 12'sd0;
        end
`endif
        else if (tick) begin
            lft_q  <= step_to(lft_d, lft_q, sz);
            rght_q <= step_to(rght_d, rght_q, sz);
        end
    end

    assign bus.lft_spd  = lft_q;
    assign bus.rght_spd = rght_q;
    assign bus.at_speed = (state == RUN) &&
                          (lft_q == bus.lft_tgt) &&
                          (rght_q == bus.rght_tgt);
    assign bus.ramping  = (state != IDLE) &&
                          ((lft_q != lft_d) || (rght_q != rght_d));
    assign bus.fault    = (state == ESTOP);

endmodule

// File: tb/tb_mtr_ramp_ctrl.sv
// tb_mtr_ramp_ctrl: scoreboard bench for mtr_ramp_ctrl.
// Expected speed pairs are queued at stimulus time and popped on each speed change.
module tb_mtr_ramp_ctrl;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];
    int          t_q[$];

    mtr_ramp_ctrl_if bus();

    mtr_ramp_ctrl #(
        .STEP(16),
        .BRAKE_STEP(64),
        .TICK_DIV(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pk(input int l, input int r);
        logic [11:0] a;
        logic [11:0] b;
        a = 12'(l);
        b = 12'(r);
        return {a, b};
    endfunction

    // Records each change of the speed pair and the edge index it appeared on.
    task automatic capture(input int n, input int budget);
        logic [23:0] prev;
        logic [23:0] cur;
        int t;
        obs_q.delete();
        t_q.delete();
        prev = {bus.lft_spd, bus.rght_spd};
        t = 0;
        while (obs_q.size() < n && t < budget) begin
            @(posedge clk);
            #1;
            t++;
            cur = {bus.lft_spd, bus.rght_spd};
            if (cur !== prev) begin
                obs_q.push_back(cur);
                t_q.push_back(t);
                prev = cur;
            end
        end
    endtask

    task automatic test_reset;
        bus.go = 0;
        bus.estop = 0;
        bus.lft_tgt = 0;
        bus.rght_tgt = 0;
        rst_n = 1;
        #3 rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.lft_spd, bus.rght_spd} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_spd: got %h want 0",
                     {bus.lft_spd, bus.rght_spd});
        end
        vectors++;
        if ({bus.at_speed, bus.ramping, bus.fault} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000",
                     {bus.at_speed, bus.ramping, bus.fault});
        end
    endtask

    task automatic test_run;
        logic [23:0] e;
        logic [23:0] o;
        int lv[7] = '{16, 32, 48, 64, 80, 96, 100};
        int rv[7] = '{-16, -32, -48, -50, -50, -50, -50};
        for (int i = 0; i < 7; i++) exp_q.push_back(pk(lv[i], rv[i]));
        bus.lft_tgt = 100;
        bus.rght_tgt = -50;
        bus.go = 1;
        capture(7, 60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            if (o !== e) begin
                miscompares++;
                $display("FAIL run_seq: got %h want %h", o, e);
            end
        end
        vectors++;
        if (t_q.size() != 7 || t_q[6] != 29) begin
            miscompares++;
            $display("FAIL run_time: got %0d want 29",
                     (t_q.size() > 0) ? t_q[t_q.size()-1] : -1);
        end
        vectors++;
        if ({bus.at_speed, bus.ramping} !== 2'b10) begin
            miscompares++;
            $display("FAIL run_flags: got %b want 10",
                     {bus.at_speed, bus.ramping});
        end
    endtask

    task automatic test_stop;
        logic [23:0] e;
        logic [23:0] o;
        int lv[7] = '{84, 68, 52, 36, 20, 4, 0};
        int rv[7] = '{-34, -18, -2, 0, 0, 0, 0};
        for (int i = 0; i < 7; i++) exp_q.push_back(pk(lv[i], rv[i]));
        bus.go = 0;
        capture(7, 60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            if (o !== e) begin
                miscompares++;
                $display("FAIL stop_seq: got %h want %h", o, e);
            end
        end
        vectors++;
        if (bus.at_speed !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_at_speed: got %b want 0", bus.at_speed);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_redirect;
        logic [23:0] e;
        logic [23:0] o;
        int lv[10] = '{16, 32, 48, 32, 16, 0, -16, -20, -4, 0};
        for (int i = 0; i < 10; i++) exp_q.push_back(pk(lv[i], 0));
        bus.lft_tgt = 100;
        bus.rght_tgt = 0;
        bus.go = 1;
        capture(3, 30);
        bus.lft_tgt = -20;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            if (o !== e) begin
                miscompares++;
                $display("FAIL redir_up: got %h want %h", o, e);
            end
        end
        capture(5, 40);
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            if (o !== e) begin
                miscompares++;
                $display("FAIL redir_down: got %h want %h", o, e);
            end
        end
        vectors++;
        if (bus.at_speed !== 1'b1) begin
            miscompares++;
            $display("FAIL redir_at_speed: got %b want 1", bus.at_speed);
        end
        bus.go = 0;
        capture(2, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            if (o !== e) begin
                miscompares++;
                $display("FAIL redir_stop: got %h want %h", o, e);
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_extremes;
        logic [23:0] e;
        logic [23:0] o;
        int bad;
        for (int k = 1; k < 128; k++) exp_q.push_back(pk(16 * k, -16 * k));
        exp_q.push_back(pk(2047, -2048));
        bus.lft_tgt = 2047;
        bus.rght_tgt = -2048;
        bus.go = 1;
        capture(128, 600);
        bad = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            if (o !== e && bad < 4) begin
                bad++;
                $display("FAIL ext_up: got %h want %h", o, e);
            end
            if (o !== e) miscompares++;
        end
        for (int k = 1; k < 128; k++)
            exp_q.push_back(pk(2047 - 16 * k, -2048 + 16 * k));
        exp_q.push_back(pk(0, 0));
        bus.go = 0;
        capture(128, 600);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            if (o !== e && bad < 8) begin
                bad++;
                $display("FAIL ext_down: got %h want %h", o, e);
            end
            if (o !== e) miscompares++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_estop;
        logic [23:0] e;
        logic [23:0] o;
        bus.lft_tgt = 100;
        bus.rght_tgt = -50;
        bus.go = 1;
        capture(7, 60);
        vectors++;
        if ({bus.lft_spd, bus.rght_spd} !== pk(100, -50)) begin
            miscompares++;
            $display("FAIL estop_pre: got %h want %h",
                     {bus.lft_spd, bus.rght_spd}, pk(100, -50));
        end
        bus.estop = 1;
`ifdef MTR_RAMP_BRAKE_EN
        exp_q.push_back(pk(36, 0));
        exp_q.push_back(pk(0, 0));
        capture(2, 20);
`else
        exp_q.push_back(pk(0, 0));
        capture(1, 5);
        vectors++;
        if (t_q.size() != 1 || t_q[0] != 1) begin
            miscompares++;
            $display("FAIL estop_time: got %0d want 1",
                     (t_q.size() > 0) ? t_q[0] : -1);
        end
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            if (o !== e) begin
                miscompares++;
                $display("FAIL estop_seq: got %h want %h", o, e);
            end
        end
        vectors++;
        if (bus.fault !== 1'b1) begin
            miscompares++;
            $display("FAIL estop_fault: got %b want 1", bus.fault);
        end
        bus.estop = 0;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (bus.fault !== 1'b1 || bus.at_speed !== 1'b0) begin
            miscompares++;
            $display("FAIL estop_hold: got fault %b at_speed %b want 1 0",
                     bus.fault, bus.at_speed);
        end
        bus.go = 0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.fault !== 1'b0) begin
            miscompares++;
            $display("FAIL estop_exit: got %b want 0", bus.fault);
        end
    endtask

    task automatic test_reset_mid;
        logic [23:0] e;
        logic [23:0] o;
        bus.lft_tgt = 100;
        bus.rght_tgt = -50;
        bus.go = 1;
        capture(3, 30);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({bus.lft_spd, bus.rght_spd} !== 24'h0 || bus.ramping !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: got %h ramping %b want 0 0",
                     {bus.lft_spd, bus.rght_spd}, bus.ramping);
        end
        bus.go = 0;
        #10 rst_n = 1;
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if ({bus.lft_spd, bus.rght_spd} !== 24'h0 || bus.ramping !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_idle: got %h ramping %b want 0 0",
                     {bus.lft_spd, bus.rght_spd}, bus.ramping);
        end
        exp_q.push_back(pk(16, -16));
        bus.go = 1;
        capture(1, 10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 24'hxxxxxx;
            if (o !== e) begin
                miscompares++;
                $display("FAIL rst_restart: got %h want %h", o, e);
            end
        end
        vectors++;
        if (t_q.size() != 1 || t_q[0] != 5) begin
            miscompares++;
            $display("FAIL rst_restart_time: got %0d want 5",
                     (t_q.size() > 0) ? t_q[0] : -1);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_run();
        test_stop();
        test_redirect();
        test_extremes();
        test_estop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
